// File: rtl/monitor_execucao.sv
// Execution monitor for the multicycle core: counts enabled cycles up to a
// programmable limit, stops on limit or halt state, and records every state
// change with its timestamp in a show-ahead trace FIFO drained via valid/ready.
module monitor_execucao #(
  parameter int unsigned            STATE_WIDTH = 4,
  parameter int unsigned            CNT_WIDTH   = 6,
  parameter int unsigned            DEPTH       = 8,
  parameter logic [STATE_WIDTH-1:0] HALT_STATE  = 4'b1111
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [STATE_WIDTH-1:0] state_in,
  input  logic [CNT_WIDTH-1:0]   limit,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [STATE_WIDTH-1:0] rd_state,
  output logic [CNT_WIDTH-1:0]   rd_time,
  output logic [CNT_WIDTH-1:0]   cycle_count,
  output logic                   done,
  output logic                   timeout,
  output logic                   overflow
);

  localparam int unsigned AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [CNT_WIDTH-1:0]   cycle_q, cycle_d;
  logic [STATE_WIDTH-1:0] prev_q, prev_d;
  logic                   first_q, first_d;
  logic                   done_q, done_d;
  logic                   timeout_q, timeout_d;
  logic                   overflow_q, overflow_d;
  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [AW:0]            wr_q, wr_d;
  logic [AW:0]            rd_q, rd_d;

  logic [STATE_WIDTH-1:0] st_mem_q [DEPTH];
  logic [CNT_WIDTH-1:0]   tm_mem_q [DEPTH];

  logic                 active;
  logic                 push;
  logic                 pop;
  logic                 wr_en;
  logic                 empty;
  logic                 full;
  logic [AW:0]          occupancy;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 hit_limit;
  logic                 hit_halt;

  // Decode edge qualifiers, FIFO handshake and stop conditions.
  always_comb begin
    active    = enable & ~done_q;
    push      = active & (first_q | (state_in != prev_q));
    occupancy = wr_q - rd_q;
    empty     = (wr_q == rd_q);
    full      = (occupancy == FULL_CNT);
    pop       = ~empty & rd_ready;
    // A full FIFO still accepts a new entry when the head leaves on the same edge.
    wr_en     = push & (~full | pop);
    cnt_inc   = cycle_q + 1'b1;
    hit_limit = active & (limit != '0) & (cnt_inc == limit);
    hit_halt  = active & (state_in == HALT_STATE);
  end

  // Next-state for counter, capture tracking, sticky flags and pointers.
  always_comb begin
    cycle_d    = cycle_q;
    prev_d     = prev_q;
    first_d    = first_q;
    done_d     = done_q | hit_limit | hit_halt;
    timeout_d  = timeout_q | hit_limit;
    overflow_d = overflow_q | (push & full & ~pop);
    wr_d       = wr_q;
    rd_d       = rd_q;
    if (active) begin
      cycle_d = cnt_inc;
      prev_d  = state_in;
      first_d = 1'b0;
    end
    if (wr_en) wr_d = wr_q + 1'b1;
    if (pop)   rd_d = rd_q + 1'b1;
  end

  // Control registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q    <= '0;
      prev_q     <= '0;
      first_q    <= 1'b1;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      cycle_q    <= cycle_d;
      prev_q     <= prev_d;
      first_q    <= first_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end

  // Trace storage; contents are only observable through the valid-gated head.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      st_mem_q[wr_q[AW-1:0]] <= state_in;
      tm_mem_q[wr_q[AW-1:0]] <= cycle_q;
    end
  end

  // Registered outputs; head entry reads as zero while the FIFO is empty.
  always_comb begin
    rd_valid    = ~empty;
    rd_state    = empty ? '0 : st_mem_q[rd_q[AW-1:0]];
    rd_time     = empty ? '0 : tm_mem_q[rd_q[AW-1:0]];
    cycle_count = cycle_q;
    done        = done_q;
    timeout     = timeout_q;
    overflow    = overflow_q;
  end

endmodule

// File: tb/tb_monitor_execucao.sv
// Bench for monitor_execucao: directed scenarios plus random traffic,
// all compared against a queue-based behavioural model.
module tb_monitor_execucao;

  localparam int SW    = 4;
  localparam int CW    = 6;
  localparam int DEPTH = 8;
  localparam int HALT  = 15;
  localparam int MOD   = 1 << CW;

  logic          clk;
  logic          reset;
  logic          enable;
  logic [SW-1:0] state_in;
  logic [CW-1:0] limit;
  logic          rd_ready;
  logic          rd_valid;
  logic [SW-1:0] rd_state;
  logic [CW-1:0] rd_time;
  logic [CW-1:0] cycle_count;
  logic          done;
  logic          timeout;
  logic          overflow;

  monitor_execucao #(
    .STATE_WIDTH(SW),
    .CNT_WIDTH  (CW),
    .DEPTH      (DEPTH),
    .HALT_STATE (4'b1111)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .state_in   (state_in),
    .limit      (limit),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_state   (rd_state),
    .rd_time    (rd_time),
    .cycle_count(cycle_count),
    .done       (done),
    .timeout    (timeout),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st;
    int tm;
  } ent_t;

  ent_t m_q[$];
  int   m_cnt;
  int   m_prev;
  bit   m_first;
  bit   m_done;
  bit   m_to;
  bit   m_ov;

  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cnt   = 0;
    m_prev  = 0;
    m_first = 1'b1;
    m_done  = 1'b0;
    m_to    = 1'b0;
    m_ov    = 1'b0;
  endtask

  // One rising edge of the reference behaviour, using the currently driven inputs.
  task automatic model_edge();
    int  sz0;
    bit  pop;
    int  nxt;
    sz0 = m_q.size();
    pop = (sz0 > 0) && rd_ready;
    if (pop) void'(m_q.pop_front());
    if (enable && !m_done) begin
      if (m_first || int'(state_in) != m_prev) begin
        if (sz0 < DEPTH || pop) m_q.push_back('{st: int'(state_in), tm: m_cnt});
        else m_ov = 1'b1;
      end
      m_prev  = int'(state_in);
      m_first = 1'b0;
      nxt = (m_cnt + 1) % MOD;
      if (limit != 0 && nxt == int'(limit)) begin
        m_done = 1'b1;
        m_to   = 1'b1;
      end
      if (int'(state_in) == HALT) m_done = 1'b1;
      m_cnt = nxt;
    end
  endtask

  task automatic compare_all();
    chk("rd_valid", rd_valid, (m_q.size() != 0) ? 1 : 0);
    chk("rd_state", rd_state, (m_q.size() != 0) ? m_q[0].st : 0);
    chk("rd_time", rd_time, (m_q.size() != 0) ? m_q[0].tm : 0);
    chk("cycle_count", cycle_count, m_cnt);
    chk("done", done, m_done);
    chk("timeout", timeout, m_to);
    chk("overflow", overflow, m_ov);
  endtask

  // Called at a falling edge: drive inputs, advance model, sample at next falling edge.
  task automatic step(input int st, input bit en, input int lim, input bit rdy);
    state_in = st[SW-1:0];
    enable   = en;
    limit    = lim[CW-1:0];
    rd_ready = rdy;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst_valid_zero", rd_valid, 0);
    chk("rst_count_zero", cycle_count, 0);
    #1;
    reset = 1'b1;
  endtask

  int exp_st[4];
  int exp_tm[4];
  int lim_r;
  int st_r;

  initial begin
    n_vec    = 0;
    n_err    = 0;
    reset    = 1'b0;
    enable   = 1'b0;
    state_in = '0;
    limit    = '0;
    rd_ready = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    reset = 1'b1;

    // Limit stop
    for (int i = 0; i < 5; i++) step(2, 1'b1, 5, 1'b0);
    chk("lim_count", cycle_count, 5);
    chk("lim_done", done, 1);
    chk("lim_timeout", timeout, 1);
    chk("lim_entry_state", rd_state, 2);
    chk("lim_entry_time", rd_time, 0);
    for (int i = 0; i < 10; i++) step(2, 1'b1, 5, 1'b0);
    chk("lim_hold_count", cycle_count, 5);
    step(2, 1'b0, 5, 1'b1);
    chk("lim_single_entry", rd_valid, 0);

    // Transition trace
    do_reset();
    begin
      int seq[7];
      seq = '{0, 0, 1, 1, 1, 3, 0};
      for (int i = 0; i < 7; i++) step(seq[i], 1'b1, 0, 1'b0);
    end
    exp_st = '{0, 1, 3, 0};
    exp_tm = '{0, 2, 5, 6};
    for (int i = 0; i < 4; i++) begin
      chk("trace_state", rd_state, exp_st[i]);
      chk("trace_time", rd_time, exp_tm[i]);
      step(0, 1'b0, 0, 1'b1);
    end
    chk("trace_empty", rd_valid, 0);

    // Halt
    do_reset();
    step(1, 1'b1, 0, 1'b0);
    step(2, 1'b1, 0, 1'b0);
    step(HALT, 1'b1, 0, 1'b0);
    chk("halt_done", done, 1);
    chk("halt_timeout", timeout, 0);
    chk("halt_count", cycle_count, 3);
    step(3, 1'b1, 0, 1'b0);
    step(5, 1'b1, 0, 1'b0);
    step(5, 1'b1, 0, 1'b1);
    step(5, 1'b1, 0, 1'b1);
    chk("halt_last_state", rd_state, HALT);
    chk("halt_last_time", rd_time, 2);
    step(6, 1'b1, 0, 1'b1);
    chk("halt_no_more", rd_valid, 0);

    // Overflow
    do_reset();
    for (int i = 0; i < 10; i++) step((i % 2) ? 5 : 10, 1'b1, 0, 1'b0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head_time", rd_time, 0);
    step(10, 1'b1, 0, 1'b1);
    chk("ovf_pop_head_time", rd_time, 1);
    for (int i = 1; i < 8; i++) begin
      chk("ovf_drain_time", rd_time, i);
      step(10, 1'b0, 0, 1'b1);
    end
    chk("ovf_new_entry_time", rd_time, 10);
    chk("ovf_new_entry_state", rd_state, 10);
    step(10, 1'b0, 0, 1'b1);
    chk("ovf_drained", rd_valid, 0);

    // Enable gating
    do_reset();
    step(1, 1'b1, 0, 1'b0);
    step(1, 1'b1, 0, 1'b0);
    for (int i = 0; i < 3; i++) step(4, 1'b0, 0, 1'b0);
    chk("gate_count_held", cycle_count, 2);
    step(4, 1'b1, 0, 1'b1);
    chk("gate_capture_state", rd_state, 4);
    chk("gate_capture_time", rd_time, 2);

    // Async reset mid-run
    do_reset();
    step(1, 1'b1, 0, 1'b0);
    step(2, 1'b1, 0, 1'b0);
    step(3, 1'b1, 0, 1'b0);
    chk("mid_pre_done", done, 0);
    do_reset();
    step(7, 1'b1, 0, 1'b0);
    chk("mid_restart_state", rd_state, 7);
    chk("mid_restart_time", rd_time, 0);

    // Random traffic
    lim_r = 0;
    st_r  = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 180) == 0) do_reset();
      if ($urandom_range(0, 60) == 0)
        lim_r = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, MOD - 1));
      if ($urandom_range(0, 400) == 0) st_r = HALT;
      else if ($urandom_range(0, 2) == 0) st_r = int'($urandom_range(0, 14));
      step(st_r, ($urandom_range(0, 9) < 8), lim_r, ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
